array_bank_model: RTL

Synthesizable responder for the array side of the memory-controller array interface. It accepts row activate and precharge through `array_banksel_n`/`array_raddr`, column writes and column reads, and returns read data after a fixed latency. It checks tRCD/tRAS/tRP timing against the controller's configuration and counts refresh cycles. It is the device-side partner of the array controller in FPGA loopback builds and system benches.

---
 rtl/array_bank_model_if.sv | 44 ++++
 rtl/array_bank_model.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/array_bank_model_if.sv
// Array-side bus between the memory controller and one array bank:
// row select/address, write and read column strobes, read data return.
interface array_bank_model_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int RADDR_WIDTH = 14,
    parameter int CADDR_WIDTH = 6
);
    logic                   array_banksel_n;
    logic [RADDR_WIDTH-1:0] array_raddr;
    logic                   array_cas_wr;
    logic [CADDR_WIDTH-1:0] array_caddr_wr;
    logic                   array_wdata_rdy;
    logic [DATA_WIDTH-1:0]  array_wdata;
    logic                   array_cas_rd;
    logic [CADDR_WIDTH-1:0] array_caddr_rd;
    logic                   array_rdata_rdy;
    logic [DATA_WIDTH-1:0]  array_rdata;

    modport master (
        output array_banksel_n,
        output array_raddr,
        output array_cas_wr,
        output array_caddr_wr,
        output array_wdata_rdy,
        output array_wdata,
        output array_cas_rd,
        output array_caddr_rd,
        input  array_rdata_rdy,
        input  array_rdata
    );

    modport slave (
        input  array_banksel_n,
        input  array_raddr,
        input  array_cas_wr,
        input  array_caddr_wr,
        input  array_wdata_rdy,
        input  array_wdata,
        input  array_cas_rd,
        input  array_caddr_rd,
        output array_rdata_rdy,
        output array_rdata
    );
endinterface

// File: rtl/array_bank_model.sv
// Single-bank array responder: row open/close, column storage, fixed-latency
// read return, tRCD/tRAS/tRP and protocol checking, refresh-cycle counting.
module array_bank_model #(
    parameter int DATA_WIDTH  = 64,
    parameter int RADDR_WIDTH = 14,
    parameter int CADDR_WIDTH = 6,
    parameter int ROW_BITS    = 4,
    parameter int RD_LAT      = 2
) (
    input  logic                clk,
    input  logic                rstn,
    array_bank_model_if.slave   array_bus,
    input  logic [7:0]          mc_trcd_cfg,
    input  logic [7:0]          mc_tras_cfg,
    input  logic [7:0]          mc_trp_cfg,
    input  logic                err_clr,
    output logic [6:0]          err_flags,
    output logic [15:0]         rf_cnt
);

    localparam int AW    = ROW_BITS + CADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_activate;
    logic                   w_precharge;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_cas_any;
    logic [6:0]             w_set;

    logic [RADDR_WIDTH-1:0] r_row;
    logic [7:0]             r_ras_cnt;
    logic [7:0]             r_rp_cnt;
    logic                   r_cas_seen;
    logic [15:0]            r_rf_cnt;
    logic [6:0]             r_err;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]          w_wr_idx;
    logic [AW-1:0]          w_rd_idx;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    logic [RD_LAT-1:0]      r_vld;
    logic [DATA_WIDTH-1:0]  r_dat [RD_LAT];

    assign w_cas_any = array_bus.array_cas_wr | array_bus.array_cas_rd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_activate  = 1'b0;
        w_precharge = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_set       = '0;
        unique case (r_state)
            ST_CLOSED: begin
                if (!array_bus.array_banksel_n) begin
                    w_state_nxt = ST_OPEN;
                    w_activate  = 1'b1;
                    w_set[2]    = (r_rp_cnt < mc_trp_cfg);
                end
                w_set[3] = w_cas_any;
            end
            ST_OPEN: begin
                w_wr_en  = array_bus.array_cas_wr &
                           array_bus.array_wdata_rdy;
                w_rd_en  = array_bus.array_cas_rd;
                w_set[0] = w_cas_any & (r_ras_cnt < mc_trcd_cfg);
                w_set[4] = (array_bus.array_raddr != r_row);
                if (array_bus.array_banksel_n) begin
                    w_state_nxt = ST_CLOSED;
                    w_precharge = 1'b1;
                    w_set[1]    = (r_ras_cnt < mc_tras_cfg);
                end
            end
            default: w_state_nxt = ST_CLOSED;
        endcase
        w_set[5] = array_bus.array_cas_wr & ~array_bus.array_wdata_rdy;
        w_set[6] = array_bus.array_cas_wr & array_bus.array_cas_rd;
    end

    // Counters read k during cycle A+k / P+k, so they load 1 at the edge
    // that closes the activate/precharge cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row      <= '0;
            r_ras_cnt  <= '0;
            r_rp_cnt   <= 8'hFF;
            r_cas_seen <= 1'b0;
            r_rf_cnt   <= '0;
        end else begin
            if (w_activate) begin
                r_row     <= array_bus.array_raddr;
                r_ras_cnt <= 8'd1;
            end else if (r_state == ST_OPEN && r_ras_cnt != 8'hFF) begin
                r_ras_cnt <= r_ras_cnt + 8'd1;
            end

            if (w_precharge) begin
                r_rp_cnt <= 8'd1;
            end else if (r_state == ST_CLOSED && r_rp_cnt != 8'hFF) begin
                r_rp_cnt <= r_rp_cnt + 8'd1;
            end

            if (w_activate) begin
                r_cas_seen <= 1'b0;
            end else if (w_wr_en || w_rd_en) begin
                r_cas_seen <= 1'b1;
            end

            if (w_precharge && !(r_cas_seen || w_wr_en || w_rd_en)) begin
                r_rf_cnt <= r_rf_cnt + 16'd1;
            end
        end
    end

    // A new error in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr ? 7'd0 : r_err) | w_set;
        end
    end

    assign w_wr_idx  = {r_row[ROW_BITS-1:0], array_bus.array_caddr_wr};
    assign w_rd_idx  = {r_row[ROW_BITS-1:0], array_bus.array_caddr_rd};
    assign w_rd_data = r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= array_bus.array_wdata;
        end
    end

    // Data stages only move with a valid, so the last stage holds the
    // most recent read word between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_en;
            if (w_rd_en) begin
                r_dat[0] <= w_rd_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign array_bus.array_rdata_rdy = r_vld[RD_LAT-1];
    assign array_bus.array_rdata     = r_dat[RD_LAT-1];
    assign err_flags                 = r_err;
    assign rf_cnt                    = r_rf_cnt;

endmodule
